// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the fifo push arbiter.
//   arb_state_e : arbiter FSM states
//   DATA_W_DEF  : default byte width, matches the fifo data_in
//   idx_w()     : index width for an N-entry selector (never below 1)
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    localparam int DATA_W_DEF = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search, first set request at/after ptr.
//   req   in  N_REQ  request vector
//   ptr   in  PTR_W  search start position (0..N_REQ-1)
//   found out 1      any request set
//   idx   out PTR_W  winning index, wrapping past N_REQ-1 back to 0
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    int j;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = |req;
        idx   = '0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) idx = PTR_W'(j);
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter driving the byte fifo write port.
//   clk          in  posedge clock (fifo samples on negedge of the same net)
//   reset        in  synchronous active-high reset
//   req_valid    in  N_REQ         producer i has a byte
//   req_data     in  N_REQ*DATA_W  producer i byte at [i*DATA_W +: DATA_W]
//   req_ready    out N_REQ         beat i accepted when valid & ready
//   fifo_full    in  fifo full flag
//   fifo_push    out fifo push strobe
//   fifo_data_in out DATA_W        fifo write data
//   grant_id     out current/last granted producer
//   busy         out high while a burst is in progress
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 4,
    localparam int ID_W     = idx_w(N_REQ),
    localparam int CNT_W    = $clog2(BURST_LEN) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_push,
    output logic [DATA_W-1:0]       fifo_data_in,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(.N_REQ(N_REQ), .PTR_W(ID_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign next_ptr = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    assign grant_id = grant_id_q;
    assign busy     = (state_q == ARB_BURST);

    // Handshake outputs are gated by reset so no beat is taken while it is high,
    // and by fifo_full so the fifo can never overflow.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        fifo_push    = 1'b0;
        fifo_data_in = '0;
        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                state_d    = ARB_BURST;
                grant_id_d = pick_idx;
                beat_cnt_d = '0;
            end
        end else begin
            req_ready[grant_id_q] = !fifo_full && !reset;
            fifo_push             = req_valid[grant_id_q] && !fifo_full && !reset;
            fifo_data_in          = req_data[grant_id_q*DATA_W +: DATA_W];
            if (!req_valid[grant_id_q]) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = next_ptr;
            end else if (fifo_push) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
                if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: randomized bench against a transaction-level arbiter model.
module tb_fifo_push_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int BL   = 4;
    localparam int IW   = 2;
    localparam int FDEP = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_push;
    logic [DW-1:0]   fifo_data_in;
    logic [IW-1:0]   grant_id;
    logic            busy;

    int checks = 0;
    int failures = 0;

    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_beats = 0;
    int occ = 0;
    int p_valid, p_pop, p_rst, cyc;

    fifo_push_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_push    (fifo_push),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_push();
        return m_busy && req_valid[m_owner] && !fifo_full && !reset;
    endfunction

    // Advance the model over the cycle that just ended, using the inputs held during it.
    task automatic step();
        bit push;
        push = exp_push();
        if (push) occ++;
        if (occ > 0 && $urandom_range(99) < p_pop) occ--;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[(m_ptr + k) % N]) begin
                    m_busy = 1; m_owner = (m_ptr + k) % N; m_beats = 0;
                    break;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 0; m_ptr = (m_owner + 1) % N;
        end else if (push) begin
            m_beats++;
            if (m_beats == BL) begin
                m_busy = 0; m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic drive(input bit force_rst);
        reset = force_rst || ($urandom_range(999) < p_rst);
        for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(99) < p_valid);
        req_data  = $urandom;
        fifo_full = (occ >= FDEP);
    endtask

    task automatic check_outputs();
        chk(reset && cyc < 3 ? "rst_busy" : "busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("req_ready", 32'(req_ready), (m_busy && !fifo_full && !reset) ? (32'd1 << m_owner) : 32'd0);
        chk("fifo_push", 32'(fifo_push), 32'(exp_push()));
        chk("fifo_data_in", 32'(fifo_data_in), m_busy ? 32'(req_data[m_owner*DW +: DW]) : 32'd0);
        chk("no_overflow", 32'(fifo_push && fifo_full), 32'd0);
    endtask

    task automatic run_phase(input int pv, input int pp, input int pr, input int n);
        p_valid = pv; p_pop = pp; p_rst = pr;
        repeat (n) begin
            @(posedge clk);
            #1;
            step();
            drive(cyc < 2);
            cyc++;
            #1;
            check_outputs();
        end
    endtask

    initial begin
        cyc = 0;
        run_phase(100, 100, 0, 60);
        run_phase(90, 60, 0, 300);
        run_phase(50, 30, 0, 300);
        run_phase(100, 10, 0, 200);
        run_phase(30, 80, 20, 300);
        run_phase(100, 100, 40, 300);
        run_phase(80, 50, 5, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
